// File: rtl/pll_drp_model.sv
// pll_drp_model: DRP responder with a 32x16 register file, fixed-latency replies and emulated PLL lock
module pll_drp_model #(
  parameter int          RD_LAT   = 3,
  parameter int          WR_LAT   = 2,
  parameter int          LOCK_CYC = 64,
  parameter logic [7:0]  INIT_HI  = 8'hA5
) (
  input  logic        CLK,
  input  logic        RSTX,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [4:0]  DADDR,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        DRDY,
  input  logic        RST_PLL,
  output logic        LOCKED,
  output logic [1:0]  ERR,
  input  logic        ERR_CLR
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
  localparam logic [3:0] RD_L     = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_L     = 4'(WR_LAT - 1);
  localparam logic [9:0] LOCK_MAX = 10'(LOCK_CYC);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] di_q, di_d;
  logic [15:0] regs_q [32];
  logic [15:0] regs_d [32];
  logic [9:0]  lock_q, lock_d;
  logic [1:0]  err_q, err_d;
  logic        accept, done;
  always_comb begin
    accept  = state_q == IDLE && DEN;
    done    = state_q != IDLE && cnt_q == 4'd0;
    state_d = accept ? (DWE ? WR_WAIT : RD_WAIT) : done ? IDLE : state_q;
    cnt_d   = accept ? (DWE ? WR_L : RD_L) : (state_q != IDLE && !done) ? cnt_q - 4'd1 : cnt_q;
    addr_d  = accept ? DADDR : addr_q;
    di_d    = accept ? DI : di_q;
    regs_d  = regs_q;
    if (done && state_q == WR_WAIT) regs_d[addr_q] = di_q;
    // a new error in the same cycle as ERR_CLR survives the clear
    err_d   = (ERR_CLR ? 2'b00 : err_q) | {accept && DWE && !RST_PLL, DEN && state_q != IDLE};
    lock_d  = RST_PLL ? 10'd0 : (lock_q == LOCK_MAX) ? lock_q : lock_q + 10'd1;
  end
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 5'd0;
      di_q    <= 16'd0;
      lock_q  <= 10'd0;
      err_q   <= 2'b00;
      for (int a = 0; a < 32; a++) regs_q[a] <= {INIT_HI, 3'b000, 5'(a)};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end
  assign DRDY   = done;
  assign DO     = (done && state_q == RD_WAIT) ? regs_q[addr_q] : 16'd0;
  assign LOCKED = lock_q == LOCK_MAX;
  assign ERR    = err_q;
endmodule

// File: tb/tb_pll_drp_model.sv
// tb_pll_drp_model: directed bench for the DRP responder (latency, register file, errors, lock, reset)
module tb_pll_drp_model;
  logic        CLK = 1'b0, RSTX = 1'b0, DEN = 1'b0, DWE = 1'b0, RST_PLL = 1'b1, ERR_CLR = 1'b0;
  logic [4:0]  DADDR = 5'd0;
  logic [15:0] DI = 16'd0, DO;
  logic        DRDY, LOCKED;
  logic [1:0]  ERR;
  int n_cmp = 0, n_bad = 0;

  pll_drp_model dut (
    .CLK(CLK), .RSTX(RSTX), .DEN(DEN), .DWE(DWE), .DADDR(DADDR), .DI(DI), .DO(DO),
    .DRDY(DRDY), .RST_PLL(RST_PLL), .LOCKED(LOCKED), .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // issue one request and wait (bounded) for DRDY; lat = -1 if it never comes
  task automatic txn(input logic we, input logic [4:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output int lat);
    tick;
    DEN = 1'b1; DWE = we; DADDR = a; DI = d;
    lat = -1; rd = 16'd0;
    for (int i = 0; i < 20; i++) begin
      tick;
      DEN = 1'b0;
      if (DRDY) begin lat = i + 1; rd = DO; break; end
    end
  endtask

  task automatic test_reset;
    tick; tick;
    n_cmp++; if (DO !== 16'd0) begin n_bad++; $display("FAIL rst_do got %h want 0000", DO); end
    n_cmp++; if (DRDY !== 1'b0) begin n_bad++; $display("FAIL rst_drdy got %b want 0", DRDY); end
    n_cmp++; if (LOCKED !== 1'b0) begin n_bad++; $display("FAIL rst_locked got %b want 0", LOCKED); end
    n_cmp++; if (ERR !== 2'b00) begin n_bad++; $display("FAIL rst_err got %b want 00", ERR); end
    RSTX = 1'b1;
  endtask

  task automatic test_read;
    tick;
    DEN = 1'b1; DWE = 1'b0; DADDR = 5'h07;
    n_cmp++; if (DRDY !== 1'b0) begin n_bad++; $display("FAIL rd_t0_drdy got %b want 0", DRDY); end
    tick; DEN = 1'b0;
    n_cmp++; if (DRDY !== 1'b0) begin n_bad++; $display("FAIL rd_t1_drdy got %b want 0", DRDY); end
    tick;
    n_cmp++; if (DRDY !== 1'b0) begin n_bad++; $display("FAIL rd_t2_drdy got %b want 0", DRDY); end
    n_cmp++; if (DO !== 16'd0) begin n_bad++; $display("FAIL rd_t2_do got %h want 0000", DO); end
    tick;
    n_cmp++; if (DRDY !== 1'b1) begin n_bad++; $display("FAIL rd_t3_drdy got %b want 1", DRDY); end
    n_cmp++; if (DO !== 16'hA507) begin n_bad++; $display("FAIL rd_t3_do got %h want a507", DO); end
    tick;
    n_cmp++; if (DRDY !== 1'b0) begin n_bad++; $display("FAIL rd_t4_drdy got %b want 0", DRDY); end
    n_cmp++; if (DO !== 16'd0) begin n_bad++; $display("FAIL rd_t4_do got %h want 0000", DO); end
  endtask

  task automatic test_write;
    logic [15:0] rd;
    int lat;
    txn(1'b1, 5'h1F, 16'h1234, rd, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_lat got %0d want 2", lat); end
    n_cmp++; if (rd !== 16'd0) begin n_bad++; $display("FAIL wr_do got %h want 0000", rd); end
    n_cmp++; if (ERR !== 2'b00) begin n_bad++; $display("FAIL wr_err got %b want 00", ERR); end
    txn(1'b0, 5'h1F, 16'h0000, rd, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd1f_lat got %0d want 3", lat); end
    n_cmp++; if (rd !== 16'h1234) begin n_bad++; $display("FAIL rd1f_data got %h want 1234", rd); end
    txn(1'b0, 5'h1E, 16'h0000, rd, lat);
    n_cmp++; if (rd !== 16'hA51E) begin n_bad++; $display("FAIL rd1e_data got %h want a51e", rd); end
  endtask

  task automatic test_overlap;
    tick;
    DEN = 1'b1; DWE = 1'b0; DADDR = 5'h03;
    tick;
    DADDR = 5'h04;
    n_cmp++; if (DRDY !== 1'b0) begin n_bad++; $display("FAIL ov_t1_drdy got %b want 0", DRDY); end
    tick; DEN = 1'b0;
    n_cmp++; if (ERR !== 2'b01) begin n_bad++; $display("FAIL ov_err_set got %b want 01", ERR); end
    tick;
    DEN = 1'b1; DADDR = 5'h04;
    n_cmp++; if (DRDY !== 1'b1) begin n_bad++; $display("FAIL ov_t3_drdy got %b want 1", DRDY); end
    n_cmp++; if (DO !== 16'hA503) begin n_bad++; $display("FAIL ov_t3_do got %h want a503", DO); end
    tick;
    DEN = 1'b1; DADDR = 5'h06; ERR_CLR = 1'b1;
    n_cmp++; if (DRDY !== 1'b0) begin n_bad++; $display("FAIL ov_t4_drdy got %b want 0", DRDY); end
    n_cmp++; if (ERR !== 2'b01) begin n_bad++; $display("FAIL ov_t4_err got %b want 01", ERR); end
    tick;
    DEN = 1'b0; ERR_CLR = 1'b0;
    n_cmp++; if (ERR !== 2'b00) begin n_bad++; $display("FAIL ov_clr_err got %b want 00", ERR); end
    n_cmp++; if (DRDY !== 1'b0) begin n_bad++; $display("FAIL ov_t5_drdy got %b want 0", DRDY); end
    tick;
    n_cmp++; if (DRDY !== 1'b0) begin n_bad++; $display("FAIL ov_t6_drdy got %b want 0", DRDY); end
    tick;
    n_cmp++; if (DRDY !== 1'b1) begin n_bad++; $display("FAIL ov_t7_drdy got %b want 1", DRDY); end
    n_cmp++; if (DO !== 16'hA506) begin n_bad++; $display("FAIL ov_t7_do got %h want a506", DO); end
  endtask

  task automatic test_err_priority;
    tick;
    DEN = 1'b1; DWE = 1'b0; DADDR = 5'h02;
    tick;
    ERR_CLR = 1'b1;
    tick;
    DEN = 1'b0; ERR_CLR = 1'b0;
    n_cmp++; if (ERR !== 2'b01) begin n_bad++; $display("FAIL prio_err got %b want 01", ERR); end
    tick;
    n_cmp++; if (DO !== 16'hA502) begin n_bad++; $display("FAIL prio_do got %h want a502", DO); end
    tick; ERR_CLR = 1'b1;
    tick; ERR_CLR = 1'b0;
    n_cmp++; if (ERR !== 2'b00) begin n_bad++; $display("FAIL prio_clr got %b want 00", ERR); end
  endtask

  task automatic test_write_running;
    logic [15:0] rd;
    int lat;
    RST_PLL = 1'b0;
    txn(1'b1, 5'h00, 16'h0001, rd, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wrr_lat got %0d want 2", lat); end
    n_cmp++; if (ERR !== 2'b10) begin n_bad++; $display("FAIL wrr_err got %b want 10", ERR); end
    txn(1'b0, 5'h00, 16'h0000, rd, lat);
    n_cmp++; if (rd !== 16'h0001) begin n_bad++; $display("FAIL wrr_data got %h want 0001", rd); end
  endtask

  task automatic test_lock;
    tick; RST_PLL = 1'b1;
    repeat (4) tick;
    n_cmp++; if (LOCKED !== 1'b0) begin n_bad++; $display("FAIL lk_in_rst got %b want 0", LOCKED); end
    tick; RST_PLL = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick;
      if (k == 1 || k == 63) begin
        n_cmp++; if (LOCKED !== 1'b0) begin n_bad++; $display("FAIL lk_u%0d got %b want 0", k, LOCKED); end
      end
      if (k == 64) begin
        n_cmp++; if (LOCKED !== 1'b1) begin n_bad++; $display("FAIL lk_u64 got %b want 1", LOCKED); end
      end
    end
    tick; RST_PLL = 1'b1;
    n_cmp++; if (LOCKED !== 1'b1) begin n_bad++; $display("FAIL lk_pulse_p got %b want 1", LOCKED); end
    tick; RST_PLL = 1'b0;
    n_cmp++; if (LOCKED !== 1'b0) begin n_bad++; $display("FAIL lk_pulse_p1 got %b want 0", LOCKED); end
    for (int k = 2; k <= 65; k++) begin
      tick;
      if (k == 64) begin
        n_cmp++; if (LOCKED !== 1'b0) begin n_bad++; $display("FAIL lk_p64 got %b want 0", LOCKED); end
      end
      if (k == 65) begin
        n_cmp++; if (LOCKED !== 1'b1) begin n_bad++; $display("FAIL lk_p65 got %b want 1", LOCKED); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd;
    int lat;
    int seen;
    txn(1'b1, 5'h1F, 16'h5A5A, rd, lat);
    tick;
    DEN = 1'b1; DWE = 1'b0; DADDR = 5'h1F;
    tick;
    DEN = 1'b0; RSTX = 1'b0;
    #1;
    n_cmp++; if (DRDY !== 1'b0 || DO !== 16'd0) begin n_bad++; $display("FAIL rm_async got drdy=%b do=%h want 0/0000", DRDY, DO); end
    seen = 0;
    repeat (3) begin tick; if (DRDY) seen++; end
    RSTX = 1'b1;
    repeat (6) begin tick; if (DRDY || DO !== 16'd0) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rm_no_drdy got %0d stray cycles want 0", seen); end
    txn(1'b0, 5'h1F, 16'h0000, rd, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rm_lat got %0d want 3", lat); end
    n_cmp++; if (rd !== 16'hA51F) begin n_bad++; $display("FAIL rm_data got %h want a51f", rd); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_overlap;
    test_err_priority;
    test_write_running;
    test_lock;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
